// File: rtl/mph_project_sequencer.sv
// mph_project_sequencer
// Wishbone-mapped project selector for the multi-project harness. Owns the
// shared project-select bus, per-project resets and per-project update strobes.
// A CTRL write holds every project in reset for RESET_CYCLES, then releases
// only the selected one. DATA writes become one-cycle strobes to the running
// project.
// Optional feature: define MPH_DROP_COUNT_EN to add an 8-bit saturating
// counter of dropped DATA writes at STATUS[23:16].
module mph_project_sequencer #(
    parameter int          NUM_PROJECTS = 8,
    parameter int          SEL_W        = 3,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          RESET_CYCLES = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [SEL_W-1:0]        proj_sel,
    output logic [NUM_PROJECTS-1:0] proj_reset,
    output logic [NUM_PROJECTS-1:0] proj_wb_update,
    output logic [31:0]             proj_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [SEL_W:0] LP_NP       = NUM_PROJECTS[SEL_W:0];
    localparam logic [7:0]     LP_CNT_LAST = 8'(RESET_CYCLES - 1);

    state_t                  r_state, w_state_nxt;
    logic [SEL_W-1:0]        r_sel, w_sel_nxt;
    logic [7:0]              r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]        r_ctrl_tgt;
    logic                    r_ctrl_en;
    logic                    r_ack;
    logic [31:0]             r_rdata;
    logic [NUM_PROJECTS-1:0] r_upd;
    logic [31:0]             r_pdata;
    logic                    r_drop;
`ifdef MPH_DROP_COUNT_EN
    logic [7:0]              r_drop_cnt;
`endif

    logic                    w_acc, w_wr, w_ctrl_wr, w_stat_wr, w_data_wr;
    logic                    w_tgt_ok, w_en;
    logic [SEL_W-1:0]        w_target;
    logic [31:0]             w_status, w_rdata;
    logic [NUM_PROJECTS-1:0] w_onehot;
    logic                    w_unused_sel;

    // Byte selects carry no meaning here: every write is full-word.
    assign w_unused_sel = ^wbs_sel_i;

    // Request decode: a new request is only taken while ack is low, so a held
    // strobe is acknowledged every other cycle.
    always_comb begin
        w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        w_wr      = w_acc & wbs_we_i;
        w_ctrl_wr = w_wr & (wbs_adr_i[3:0] == 4'h0);
        w_stat_wr = w_wr & (wbs_adr_i[3:0] == 4'h4);
        w_data_wr = w_wr & (wbs_adr_i[3:0] == 4'h8);
        w_target  = wbs_dat_i[SEL_W-1:0];
        w_en      = wbs_dat_i[8];
        w_tgt_ok  = ({1'b0, w_target} < LP_NP);
    end

    // Next-state logic; a CTRL write always beats the HOLD terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        if (w_ctrl_wr && w_tgt_ok) begin
            if (!w_en) begin
                w_state_nxt = S_IDLE;
            end else if (!(r_state == S_RUN && w_target == r_sel)) begin
                w_state_nxt = S_HOLD;
                w_sel_nxt   = w_target;
                w_cnt_nxt   = 8'd0;
            end
        end else if (r_state == S_HOLD) begin
            if (r_cnt == LP_CNT_LAST) begin
                w_state_nxt = S_RUN;
            end else begin
                w_cnt_nxt = r_cnt + 8'd1;
            end
        end
    end

    // State, selected project and guard counter registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Per-project decode of the running project: one-hot strobe select and resets.
    always_comb begin
        w_onehot   = '0;
        proj_reset = '1;
        for (int i = 0; i < NUM_PROJECTS; i++) begin
            w_onehot[i]   = (r_sel == SEL_W'(i));
            proj_reset[i] = ~(r_state == S_RUN && r_sel == SEL_W'(i));
        end
    end

    // Read mux; values reflect register state before this request's side effects.
    always_comb begin
        w_status           = 32'h0;
        w_status[SEL_W-1:0] = r_sel;
        w_status[8]        = (r_state == S_HOLD);
        w_status[9]        = r_drop;
`ifdef MPH_DROP_COUNT_EN
        w_status[23:16]    = r_drop_cnt;
`endif
        w_rdata = 32'h0;
        case (wbs_adr_i[3:0])
            4'h0: begin
                w_rdata[SEL_W-1:0] = r_ctrl_tgt;
                w_rdata[8]         = r_ctrl_en;
            end
            4'h4:    w_rdata = w_status;
            default: w_rdata = 32'h0;
        endcase
    end

    // Bus response, CTRL shadow, update strobes and drop tracking.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack      <= 1'b0;
            r_rdata    <= 32'h0;
            r_ctrl_tgt <= '0;
            r_ctrl_en  <= 1'b0;
            r_upd      <= '0;
            r_pdata    <= 32'h0;
            r_drop     <= 1'b0;
`ifdef MPH_DROP_COUNT_EN
            r_drop_cnt <= 8'd0;
`endif
        end else begin
            r_ack   <= w_acc;
            r_rdata <= (w_acc && !wbs_we_i) ? w_rdata : 32'h0;
            r_upd   <= '0;
            if (w_ctrl_wr && w_tgt_ok) begin
                r_ctrl_tgt <= w_target;
                r_ctrl_en  <= w_en;
            end
            if (w_data_wr) begin
                if (r_state == S_RUN) begin
                    r_upd   <= w_onehot;
                    r_pdata <= wbs_dat_i;
                end else begin
                    r_drop <= 1'b1;
`ifdef MPH_DROP_COUNT_EN
                    if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
`endif
                end
            end else if (w_stat_wr && wbs_dat_i[9]) begin
                r_drop <= 1'b0;
`ifdef MPH_DROP_COUNT_EN
                r_drop_cnt <= 8'd0;
`endif
            end
        end
    end

    assign wbs_ack_o      = r_ack;
    assign wbs_dat_o      = r_rdata;
    assign proj_sel       = r_sel;
    assign proj_wb_update = r_upd;
    assign proj_data      = r_pdata;
    assign busy           = (r_state == S_HOLD);

endmodule
